id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the RV32 ALU.
- Resolves operand forwarding and selects operand sources (rs1/PC, rs2/immediate).
- Registers the ALU operands and the 4-bit ALU control code, so the ALU sees clean A/B/ALUControl one cycle after issue.
- Has a valid/ready handshake with a 2-entry skid buffer, so the ALU side can back-pressure without a combinational ready path.

Parameters:
XLEN, 32, datapath width (ALU is fixed at 32; other values unsupported)
REGW, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous kill of all held entries (branch mispredict/trap)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept
in_rs1, in_rs2  in  REGW  source register indices
in_rs1_data, in_rs2_data  in  XLEN  register-file read data
in_pc, in_imm  in  XLEN  instruction PC, sign-extended immediate
in_src_a  in  1  0=rs1 operand, 1=PC (AUIPC/JAL)
in_src_b  in  1  0=rs2 operand, 1=immediate
in_alu_ctrl  in  4  ALU opcode (0000 ADD … 1100 SRA)
in_rd  in  REGW  destination index
in_reg_write  in  1  instruction writes rd
fwd_mem_we, fwd_mem_rd, fwd_mem_data  in  1/REGW/XLEN  EX/MEM producer
fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/REGW/XLEN  MEM/WB producer
out_valid  out  1  operands valid for ALU
out_ready  in  1  ALU/EX consumer accepts
out_a, out_b  out  XLEN  ALU operands A, B
out_alu_ctrl  out  4  ALU control
out_store_data  out  XLEN  forwarded rs2 value (store data), independent of in_src_b
out_rd  out  REGW  destination index
out_reg_write  out  1  destination write enable

Behaviour:
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Payload is all out_* data fields. It is captured at in_fire; the forwarding result is evaluated combinationally in the acceptance cycle.
- Forwarding per source (rs1, rs2):
  - If idx == 0, the value is 0 regardless of the fwd_* buses and in_rs*_data.
  - Else if fwd_mem_we & fwd_mem_rd == idx, use fwd_mem_data.
  - Else if fwd_wb_we & fwd_wb_rd == idx, use fwd_wb_data.
  - Else use in_rs*_data.
  - MEM has priority over WB.
- Operand selection:
  - out_a = in_src_a ? in_pc : fwd_rs1.
  - out_b = in_src_b ? in_imm : fwd_rs2.
  - out_store_data = fwd_rs2.
- FSM states: EMPTY, HALF (main reg valid), FULL (main + skid valid).
  - EMPTY: in_fire → HALF, main ← payload.
  - HALF, in_fire & !out_fire → FULL, skid ← payload.
  - HALF, in_fire & out_fire → HALF, main ← payload.
  - HALF, !in_fire & out_fire → EMPTY.
  - FULL: out_fire → HALF, main ← skid. No acceptance while FULL.
- in_ready = (state != FULL) & ~reset. It is derived from state only; no combinational path from out_ready.
- out_valid = (state != EMPTY). out_* always reflect the main register.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 per cycle with out_ready held high.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Holding rule: while out_valid & !out_ready, all out_* stay stable.
- flush:
  - State → EMPTY, both entries discarded.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
  - in_ready is 1 on the following cycle.
- reset (mid-operation included):
  - State → EMPTY; in_ready = 0 while reset is high.
  - out_valid = 0.
  - out_a, out_b, out_store_data = 0; out_alu_ctrl = 4'b0000; out_rd = 0; out_reg_write = 0.
  - Skid register also cleared.
- reset has priority over flush; flush has priority over all transfers.

Optional Feature:
- ID_EX_FORWARD_EN defined: forwarding as above.
- ID_EX_FORWARD_EN undefined:
  - fwd_* inputs are ignored; rs1/rs2 values come from in_rs*_data (x0 still forced to 0).
  - The hazard unit must stall decode instead.
  - Handshake and FSM are identical.

Test Plan:
- Reset then in_valid=1, rs1=3 (data 0x10), rs2=4 (data 0x20), src_a=0, src_b=0, ctrl=0000 → next cycle out_valid=1, out_a=0x10, out_b=0x20, out_alu_ctrl=0000.
- rs1=5, fwd_mem_we=1/rd=5/data=0xAAAA, fwd_wb_we=1/rd=5/data=0xBBBB → out_a=0xAAAA. Drop mem_we → out_a=0xBBBB. rs1=0 with both fwd rd=0 → out_a=0.
- src_a=1 pc=0x1000, src_b=1 imm=0x12345000, rs2 fwd 0x77 → out_a=0x1000, out_b=0x12345000, out_store_data=0x77.
- out_ready=0, push 3 items A, B, C back-to-back → A held on out_*, in_ready=0 after B accepted, C stalls. Raise out_ready → A, B, C emerge in order, one per cycle.
- State FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the presented item never appears.
- Reset asserted while HALF → all outputs zero and out_valid=0 next cycle; no stale entry after reset release.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage feeding the RV32 ALU.
// Resolves rs1/rs2 forwarding, selects ALU operand sources and registers
// A/B/ALU control behind a valid/ready handshake with a 2-entry skid buffer.
// Optional feature macro: ID_EX_FORWARD_EN. When it is defined, the EX/MEM and
// MEM/WB bypass buses are used. When it is undefined, the fwd_* inputs are
// ignored and the hazard unit is expected to stall decode instead.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_src_a,
  input  logic            in_src_b,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            fwd_mem_we,
  input  logic [REGW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [REGW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_store_data,
  output logic [REGW-1:0] out_rd,
  output logic            out_reg_write
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [3:0]      alu_ctrl;
    logic [REGW-1:0] rd;
    logic            reg_write;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t          state;
  payload_t        main_q, skid_q, pay;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            in_fire, out_fire;

`ifdef ID_EX_FORWARD_EN
  // Bypass mux: EX/MEM result is younger than MEM/WB, so it wins.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] idx,
    input logic [XLEN-1:0] rf,
    input logic            mem_we,
    input logic [REGW-1:0] mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_we,
    input logic [REGW-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (idx == '0)                      return '0;
    else if (mem_we && (mem_rd == idx)) return mem_data;
    else if (wb_we && (wb_rd == idx))   return wb_data;
    else                                return rf;
  endfunction

  assign rs1_val = fwd_sel(in_rs1, in_rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign rs2_val = fwd_sel(in_rs2, in_rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
`else
  // No bypass: register-file data only, x0 still reads as zero.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data};
  assign rs1_val = (in_rs1 == '0) ? '0 : in_rs1_data;
  assign rs2_val = (in_rs2 == '0) ? '0 : in_rs2_data;
`endif

  // Assemble the payload captured at acceptance.
  always_comb begin
    pay            = '0;
    pay.a          = in_src_a ? in_pc  : rs1_val;
    pay.b          = in_src_b ? in_imm : rs2_val;
    pay.store_data = rs2_val;
    pay.alu_ctrl   = in_alu_ctrl;
    pay.rd         = in_rd;
    pay.reg_write  = in_reg_write;
  end

  // Ready depends on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL) & ~reset;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_a          = main_q.a;
  assign out_b          = main_q.b;
  assign out_store_data = main_q.store_data;
  assign out_alu_ctrl   = main_q.alu_ctrl;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;

  // Occupancy FSM: main register drives the ALU, skid absorbs one extra item
  // accepted in the cycle the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= pay;
            state  <= HALF;
          end
        end
        HALF: begin
          if (in_fire && !out_fire) begin
            skid_q <= pay;
            state  <= FULL;
          end else if (in_fire && out_fire) begin
            main_q <= pay;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= HALF;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed + short random bench for id_ex_operand_stage with a FIFO scoreboard.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_pc = '0, in_imm = '0;
  logic        in_src_a = 1'b0, in_src_b = 1'b0, in_reg_write = 1'b0;
  logic [3:0]  in_alu_ctrl = '0;
  logic        fwd_mem_we = 1'b0, fwd_wb_we = 1'b0;
  logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
  logic        out_valid, out_ready = 1'b0, out_reg_write;
  logic [31:0] out_a, out_b, out_store_data;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;

  id_ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference operand value for one source.
  function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'h0;
`ifdef ID_EX_FORWARD_EN
    if (fwd_mem_we && fwd_mem_rd == idx) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_rd == idx) return fwd_wb_data;
`endif
    return rf;
  endfunction

  // Scoreboard push on accepted transfers; flush/reset discard everything held.
  always @(posedge clk) begin
    exp_t e;
    if (reset || flush) q.delete();
    else if (in_valid && in_ready) begin
      e.a    = in_src_a ? in_pc : model_fwd(in_rs1, in_rs1_data);
      e.sd   = model_fwd(in_rs2, in_rs2_data);
      e.b    = in_src_b ? in_imm : e.sd;
      e.ctrl = in_alu_ctrl;
      e.rd   = in_rd;
      e.rw   = in_reg_write;
      q.push_back(e);
    end
  end

  // Output monitor: head of the queue must be on out_* whenever valid.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid_vs_model", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        check("out_a", out_a, q[0].a);
        check("out_b", out_b, q[0].b);
        check("out_store_data", out_store_data, q[0].sd);
        check("out_alu_ctrl", {28'b0, out_alu_ctrl}, {28'b0, q[0].ctrl});
        check("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
        check("out_reg_write", {31'b0, out_reg_write}, {31'b0, q[0].rw});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Present one item and hold it until accepted (bounded wait).
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic sa, input logic sb, input logic [3:0] ctrl,
                       input logic [4:0] rd, input logic rw);
    int n;
    in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = d1; in_rs2_data = d2;
    in_pc = pc; in_imm = imm; in_src_a = sa; in_src_b = sb;
    in_alu_ctrl = ctrl; in_rd = rd; in_reg_write = rw; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state
    cycles(2);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_sd", out_store_data, 32'd0);
    check("rst_ctrl_rd_rw", {23'b0, out_alu_ctrl, out_rd, out_reg_write}, 32'd0);
    reset = 1'b0; #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic issue: rs1/rs2 from register file, one-cycle latency
    out_ready = 1'b1;
    issue(5'd3, 5'd4, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 5'd9, 1'b1);
    in_valid = 1'b0;
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_out_a", out_a, 32'h10);
    check("t1_out_b", out_b, 32'h20);
    check("t1_ctrl", {28'b0, out_alu_ctrl}, 32'd0);

    // Forwarding priority and x0
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAAAA;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'hBBBB;
    issue(5'd5, 5'd2, 32'h5555, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0001, 5'd1, 1'b1);
    fwd_mem_we = 1'b0;
    issue(5'd5, 5'd2, 32'h5555, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0010, 5'd1, 1'b1);
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    issue(5'd0, 5'd0, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0011, 5'd2, 1'b0);
    in_valid = 1'b0;
    check("x0_out_a", out_a, 32'h0);
    check("x0_out_sd", out_store_data, 32'h0);

    // PC / immediate selection with store-data forward
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd6; fwd_mem_data = 32'h77; fwd_wb_we = 1'b0;
    issue(5'd7, 5'd6, 32'h99, 32'h66, 32'h1000, 32'h12345000, 1'b1, 1'b1, 4'b0000, 5'd8, 1'b1);
    in_valid = 1'b0;
    check("sel_out_a", out_a, 32'h1000);
    check("sel_out_b", out_b, 32'h12345000);
    fwd_mem_we = 1'b0;
    cycles(2);

    // Back-pressure: A, B fill the stage, C stalls, then all drain in order
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 32'hA1, 32'hA2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0100, 5'd10, 1'b1);
    issue(5'd1, 5'd2, 32'hB1, 32'hB2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0101, 5'd11, 1'b1);
    in_rs1_data = 32'hC1; in_rs2_data = 32'hC2; in_alu_ctrl = 4'b0110; in_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_a", out_a, 32'hA1);
      cycles(1);
    end
    out_ready = 1'b1;
    issue(5'd1, 5'd2, 32'hC1, 32'hC2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0110, 5'd12, 1'b1);
    in_valid = 1'b0;
    cycles(3);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Flush while FULL with an item presented
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 32'hE1, 32'hE2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0111, 5'd13, 1'b1);
    issue(5'd1, 5'd2, 32'hF1, 32'hF2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b1000, 5'd14, 1'b1);
    in_rs1_data = 32'hD1; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_full_in_ready", {31'b0, in_ready}, 32'd1);

    // Flush while HALF discards the same-cycle acceptance
    issue(5'd1, 5'd2, 32'h11, 32'h12, 32'h0, 32'h0, 1'b0, 1'b0, 4'b1001, 5'd15, 1'b1);
    in_rs1_data = 32'h13; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_half_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    cycles(3);
    check("flush_no_ghost", {31'b0, out_valid}, 32'd0);

    // Reset while HALF
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 32'h21, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0, 4'b1100, 5'd16, 1'b1);
    in_valid = 1'b0; reset = 1'b1;
    cycles(1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_out_a", out_a, 32'd0);
    check("midrst_out_b", out_b, 32'd0);
    check("midrst_out_sd", out_store_data, 32'd0);
    check("midrst_ctrl_rd_rw", {23'b0, out_alu_ctrl, out_rd, out_reg_write}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    cycles(3);
    check("postrst_no_stale", {31'b0, out_valid}, 32'd0);

    // Short random mix of traffic, stalls, forwarding and flushes
    for (int i = 0; i < 80; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_rs1_data  = $urandom; in_rs2_data = $urandom;
      in_pc        = $urandom; in_imm = $urandom;
      in_src_a     = 1'($urandom_range(0, 1));
      in_src_b     = 1'($urandom_range(0, 1));
      in_alu_ctrl  = 4'($urandom_range(0, 12));
      in_rd        = 5'($urandom);
      in_reg_write = 1'($urandom_range(0, 1));
      fwd_mem_we   = 1'($urandom_range(0, 1));
      fwd_mem_rd   = 5'($urandom_range(0, 7));
      fwd_mem_data = $urandom;
      fwd_wb_we    = 1'($urandom_range(0, 1));
      fwd_wb_rd    = 5'($urandom_range(0, 7));
      fwd_wb_data  = $urandom;
      cycles(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycles(4);
    check("final_drain", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
